// File: rtl/rv32im_ctrl_pipe.sv
// rv32im_ctrl_pipe: registered RV32IM decode control unit driving the ID/EX control register
// Ports:
//   i_clk, i_rst_n               clock (rising edge), asynchronous active-low reset
//   i_opcode, i_func3, i_func7   instruction fields to decode
//   i_valid, i_stall, i_flush    decode valid, external hold, pipeline flush (wins over all)
//   o_ctrl, o_illegal            registered control word and illegal-encoding flag
//   o_valid                      o_ctrl completes EX this cycle
//   o_busy                       multi-cycle MUL/DIV in EX; upstream must hold
module rv32im_ctrl_pipe #(
  parameter int NB_CTRL    = 13,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32,
  parameter int NB_CNT     = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [6:0]         i_opcode,
  input  logic [2:0]         i_func3,
  input  logic [6:0]         i_func7,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_illegal
);
  typedef enum logic {IDLE, MULTI} state_t;
  state_t state_q, state_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d, lat;
  logic [12:0] ctrl_q, ctrl_d, dec;
  logic valid_q, valid_d, ill_q, ill_d, ill;
  logic [1:0] dsz;
  // func3[1:0] 00/01/10 (byte/half/word) maps onto dataSize 01/10/11
  assign dsz = i_func3[1:0] + 2'd1;
  // word layout: {lu, mext, dataSize[1:0], ALUOp[1:0], jump, branch, memToReg, ALUSrc, memWrite, memRead, regWrite}
  always_comb begin
    dec = '0;
    ill = 1'b0;
    case (i_opcode)
      7'b0110011: begin
        dec = {1'b0, i_func7 == 7'b0000001, 2'b00, 2'b11, 7'b0000001};
        ill = !(i_func7 inside {7'b0000000, 7'b0100000, 7'b0000001});
      end
      7'b0010011: dec = {4'b0000, 2'b10, 7'b0001001};
      7'b0000011: begin
        dec = {i_func3[2], 1'b0, dsz, 2'b00, 7'b0011011};
        ill = i_func3 inside {3'b011, 3'b110, 3'b111};
      end
      7'b0100011: begin
        dec = {2'b00, dsz, 2'b00, 7'b0001100};
        ill = i_func3 > 3'b010;
      end
      7'b1100011: dec = {4'b0000, 2'b01, 7'b0100000};
      7'b1100111: dec = {4'b0000, 2'b10, 7'b1001001};
      7'b1101111: dec = {6'b000000, 7'b1000001};
      7'b0110111, 7'b0010111, 7'b1110011: dec = {6'b000000, 7'b0001001};
      default: ill = 1'b1;
    endcase
    if (ill) dec = '0;
  end
  // illegal words have mext=0, so they always take the single-cycle path
  assign lat = dec[11] ? (i_func3[2] ? NB_CNT'(DIV_CYCLES) : NB_CNT'(MUL_CYCLES)) : NB_CNT'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    ill_d   = ill_q;
    if (i_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      ctrl_d  = '0;
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else if (!i_stall) begin
      if (state_q == MULTI) begin
        cnt_d   = cnt_q - NB_CNT'(1);
        valid_d = cnt_q == NB_CNT'(1);
        state_d = cnt_q == NB_CNT'(1) ? IDLE : MULTI;
      end else if (i_valid) begin
        ctrl_d  = dec;
        ill_d   = ill;
        valid_d = lat == NB_CNT'(1);
        cnt_d   = lat - NB_CNT'(1);
        state_d = lat == NB_CNT'(1) ? IDLE : MULTI;
      end else begin
        ctrl_d  = '0;
        valid_d = 1'b0;
        ill_d   = 1'b0;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end
  assign o_ctrl    = NB_CTRL'(ctrl_q);
  assign o_valid   = valid_q;
  assign o_illegal = ill_q;
  assign o_busy    = state_q == MULTI;
endmodule

// File: tb/tb_rv32im_ctrl_pipe.sv
// tb_rv32im_ctrl_pipe: directed self-checking bench for rv32im_ctrl_pipe
module tb_rv32im_ctrl_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0, f7 = '0;
  logic [2:0] f3 = '0;
  logic vld = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [12:0] ctrl;
  logic ov, busy, ill;
  int pass_cnt = 0, total_cnt = 0;
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [12:0] exp;
    string       name;
  } vec_t;
  vec_t legal_tab [11] = '{
    '{7'b0000011, 3'b101, 7'b0, 13'h141B, "lhu"},
    '{7'b0100011, 3'b010, 7'b0, 13'h060C, "sw"},
    '{7'b0000011, 3'b000, 7'b0, 13'h021B, "lb"},
    '{7'b0000011, 3'b010, 7'b0, 13'h061B, "lw"},
    '{7'b0000011, 3'b100, 7'b0, 13'h121B, "lbu"},
    '{7'b1100011, 3'b000, 7'b0, 13'h00A0, "beq"},
    '{7'b1100111, 3'b000, 7'b0, 13'h0149, "jalr"},
    '{7'b1101111, 3'b000, 7'b0, 13'h0041, "jal"},
    '{7'b0110111, 3'b000, 7'b0, 13'h0009, "lui"},
    '{7'b1110011, 3'b000, 7'b0, 13'h0009, "system"},
    '{7'b0110011, 3'b000, 7'b0100000, 13'h0181, "sub"}
  };
  vec_t ill_tab [5] = '{
    '{7'b1111111, 3'b000, 7'b0, 13'h0, "op7f"},
    '{7'b0110011, 3'b000, 7'b0000010, 13'h0, "rfunc7"},
    '{7'b0000011, 3'b011, 7'b0, 13'h0, "ld011"},
    '{7'b0000011, 3'b110, 7'b0, 13'h0, "ld110"},
    '{7'b0100011, 3'b011, 7'b0, 13'h0, "st011"}
  };
  always #5 clk = ~clk;
  rv32im_ctrl_pipe dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(op), .i_func3(f3), .i_func7(f7),
    .i_valid(vld), .i_stall(stall), .i_flush(flush),
    .o_ctrl(ctrl), .o_valid(ov), .o_busy(busy), .o_illegal(ill)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic [6:0] s, input logic v);
    op = o; f3 = f; f7 = s; vld = v;
  endtask
  task automatic test_reset();
    #3;
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== 16'h0) $display("FAIL reset_async got=%h exp=0", {ctrl, ov, busy, ill}); else pass_cnt++;
    drive(7'b0010011, 3'b000, 7'b0, 1'b1);
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== 16'h0) $display("FAIL reset_held got=%h exp=0", {ctrl, ov, busy, ill}); else pass_cnt++;
    vld = 1'b0;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== 16'h0) $display("FAIL reset_idle got=%h exp=0", {ctrl, ov, busy, ill}); else pass_cnt++;
  endtask
  task automatic test_alu();
    drive(7'b0010011, 3'b000, 7'b0, 1'b1);
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== {13'h0109, 3'b100}) $display("FAIL addi got=%h exp=%h", {ctrl, ov, busy, ill}, {13'h0109, 3'b100}); else pass_cnt++;
    stall = 1'b1;
    drive(7'b0110011, 3'b000, 7'b0, 1'b1);
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== {13'h0109, 3'b100}) $display("FAIL stall_hold got=%h exp=%h", {ctrl, ov, busy, ill}, {13'h0109, 3'b100}); else pass_cnt++;
    stall = 1'b0;
    vld = 1'b0;
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== 16'h0) $display("FAIL bubble got=%h exp=0", {ctrl, ov, busy, ill}); else pass_cnt++;
  endtask
  task automatic test_back_to_back();
    foreach (legal_tab[i]) begin
      drive(legal_tab[i].op, legal_tab[i].f3, legal_tab[i].f7, 1'b1);
      step();
      total_cnt++;
      if ({ctrl, ov, busy, ill} !== {legal_tab[i].exp, 3'b100})
        $display("FAIL b2b_%s got=%h exp=%h", legal_tab[i].name, {ctrl, ov, busy, ill}, {legal_tab[i].exp, 3'b100});
      else pass_cnt++;
    end
    vld = 1'b0;
    step();
  endtask
  task automatic test_illegal();
    foreach (ill_tab[i]) begin
      drive(ill_tab[i].op, ill_tab[i].f3, ill_tab[i].f7, 1'b1);
      step();
      total_cnt++;
      if ({ctrl, ov, busy, ill} !== 16'h0005)
        $display("FAIL illegal_%s got=%h exp=0005", ill_tab[i].name, {ctrl, ov, busy, ill});
      else pass_cnt++;
    end
    vld = 1'b0;
    step();
    total_cnt++;
    if (ill !== 1'b0) $display("FAIL illegal_clear got=%b exp=0", ill); else pass_cnt++;
  endtask
  task automatic test_div();
    int n, busy_n;
    logic held_ok;
    drive(7'b0110011, 3'b100, 7'b0000001, 1'b1);
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== {13'h0981, 3'b010}) $display("FAIL div_start got=%h exp=%h", {ctrl, ov, busy, ill}, {13'h0981, 3'b010}); else pass_cnt++;
    drive(7'b0110011, 3'b000, 7'b0, 1'b1);
    n = 1;
    busy_n = 1;
    held_ok = 1'b1;
    while (!ov && n < 100) begin
      step();
      n++;
      if (busy) busy_n++;
      if (ctrl !== 13'h0981) held_ok = 1'b0;
    end
    total_cnt++;
    if (n !== 32) $display("FAIL div_latency got=%0d exp=32", n); else pass_cnt++;
    total_cnt++;
    if (busy_n !== 31) $display("FAIL div_busy_cycles got=%0d exp=31", busy_n); else pass_cnt++;
    total_cnt++;
    if (held_ok !== 1'b1) $display("FAIL div_ctrl_held got=%b exp=1", held_ok); else pass_cnt++;
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== {13'h0181, 3'b100}) $display("FAIL add_after_div got=%h exp=%h", {ctrl, ov, busy, ill}, {13'h0181, 3'b100}); else pass_cnt++;
    vld = 1'b0;
    step();
  endtask
  task automatic test_stall_flush();
    int m;
    drive(7'b0110011, 3'b101, 7'b0000001, 1'b1);
    step();
    m = 1;
    vld = 1'b0;
    repeat (2) begin step(); m++; end
    stall = 1'b1;
    drive(7'b0010011, 3'b000, 7'b0, 1'b1);
    repeat (5) begin step(); m++; end
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== {13'h0981, 3'b010}) $display("FAIL stall_multi_hold got=%h exp=%h", {ctrl, ov, busy, ill}, {13'h0981, 3'b010}); else pass_cnt++;
    stall = 1'b0;
    vld = 1'b0;
    while (!ov && m < 100) begin step(); m++; end
    total_cnt++;
    if (m !== 37) $display("FAIL stall_latency got=%0d exp=37", m); else pass_cnt++;
    step();
    drive(7'b0110011, 3'b110, 7'b0000001, 1'b1);
    step();
    vld = 1'b0;
    repeat (4) step();
    flush = 1'b1;
    stall = 1'b1;
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== 16'h0) $display("FAIL flush_multi got=%h exp=0", {ctrl, ov, busy, ill}); else pass_cnt++;
    stall = 1'b0;
    drive(7'b0010011, 3'b000, 7'b0, 1'b1);
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== 16'h0) $display("FAIL flush_blocks_accept got=%h exp=0", {ctrl, ov, busy, ill}); else pass_cnt++;
    flush = 1'b0;
    vld = 1'b0;
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== 16'h0) $display("FAIL flush_no_resume got=%h exp=0", {ctrl, ov, busy, ill}); else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    drive(7'b0110011, 3'b100, 7'b0000001, 1'b1);
    step();
    vld = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== 16'h0) $display("FAIL reset_mid_div got=%h exp=0", {ctrl, ov, busy, ill}); else pass_cnt++;
    #1 rst_n = 1'b1;
    drive(7'b0110011, 3'b000, 7'b0000001, 1'b1);
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== {13'h0981, 3'b100}) $display("FAIL mul_1cycle got=%h exp=%h", {ctrl, ov, busy, ill}, {13'h0981, 3'b100}); else pass_cnt++;
    drive(7'b0110011, 3'b011, 7'b0000001, 1'b1);
    step();
    total_cnt++;
    if ({ctrl, ov, busy, ill} !== {13'h0981, 3'b100}) $display("FAIL mulhu_1cycle got=%h exp=%h", {ctrl, ov, busy, ill}, {13'h0981, 3'b100}); else pass_cnt++;
    vld = 1'b0;
    step();
  endtask
  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_illegal();
    test_div();
    test_stall_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
